// File: rtl/and_reduce_pipe.sv
// and_reduce_pipe
// Two-stage pipelined masked AND/NOR reduction over WIDTH input bits.
//   Stage 1: effective bits are split LSB-first into NG = ceil(WIDTH/GROUP)
//            groups and each group AND is registered with a stage-1 valid.
//   Stage 2: the AND of all group results is registered onto Q with OUT_VALID.
// ZMODE selects all-ones (0) or all-zeros (1) testing and travels with its beat.
// A masked-out bit always counts as true, so an all-zero MASK yields Q=1.
//
// Optional feature: define AND_REDUCE_DEBOUNCE_EN to build the debounce
// counter that drives Q_STABLE after DEB_CNT consecutive valid true results.
// Without the macro Q_STABLE is tied to 0 and no counter exists.

module and_reduce_pipe #(
    parameter int WIDTH   = 27,
    parameter int GROUP   = 9,
    parameter int DEB_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] I,
    input  logic [WIDTH-1:0] MASK,
    input  logic             ZMODE,
    input  logic             IN_VALID,
    output logic             Q,
    output logic             OUT_VALID,
    output logic             Q_STABLE
);

    // Number of first-stage groups and the padded width they span.
    localparam int NG   = (WIDTH + GROUP - 1) / GROUP;
    localparam int PADW = NG * GROUP;

    // Effective bits, padded with ones above WIDTH so the top group is neutral.
    logic [PADW-1:0] eff_s;
    // Per-group AND results feeding stage 1.
    logic [NG-1:0]   grp_d;

    // Stage-1 state.
    logic [NG-1:0]   grp_q;
    logic            v1_q;

    // Stage-2 state.
    logic            q_q;
    logic            ov_q;
    logic            q_d;
    logic            ov_d;

    // Build the effective bit vector from data, mask and per-beat mode.
    always_comb begin
        eff_s = {PADW{1'b1}};
        for (int k = 0; k < WIDTH; k++) begin
            if (ZMODE) begin
                eff_s[k] = ~I[k] | ~MASK[k];
            end else begin
                eff_s[k] = I[k] | ~MASK[k];
            end
        end
    end

    // Reduce each GROUP-wide slice of the effective bits to one bit.
    always_comb begin
        grp_d = {NG{1'b0}};
        for (int g = 0; g < NG; g++) begin
            grp_d[g] = &eff_s[g*GROUP +: GROUP];
        end
    end

    // Stage 1: capture group results only for valid beats; valid always follows IN_VALID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_q <= {NG{1'b0}};
            v1_q  <= 1'b0;
        end else begin
            if (IN_VALID) begin
                grp_q <= grp_d;
            end else begin
                grp_q <= grp_q;
            end
            v1_q <= IN_VALID;
        end
    end

    // Stage-2 next state: new result on a valid stage-1 beat, otherwise hold Q.
    always_comb begin
        q_d  = q_q;
        ov_d = v1_q;
        if (v1_q) begin
            q_d = &grp_q;
        end else begin
            q_d = q_q;
        end
    end

    // Stage 2: register the final reduction and its valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q  <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            ov_q <= ov_d;
        end
    end

    assign Q         = q_q;
    assign OUT_VALID = ov_q;

`ifdef AND_REDUCE_DEBOUNCE_EN

    // Saturation threshold in counter width.
    localparam logic [7:0] DEB_MAX = 8'(DEB_CNT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       stable_q;
    logic       stable_d;

    // Debounce counter next state: count valid trues, clear on valid false, hold otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (ov_q) begin
            if (q_q) begin
                if (cnt_q < DEB_MAX) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = DEB_MAX;
                end
            end else begin
                cnt_d = 8'd0;
            end
        end else begin
            cnt_d = cnt_q;
        end
        stable_d = (cnt_d == DEB_MAX);
    end

    // Debounce registers: stable rises on the edge that counts the threshold result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 8'd0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign Q_STABLE = stable_q;

`else

    // Debounce not built: stable indication is permanently low.
    assign Q_STABLE = 1'b0;

`endif

endmodule

// File: tb/tb_and_reduce_pipe.sv
// Directed self-checking bench for and_reduce_pipe.
// Two instances: default parameters (27/9) and WIDTH=10, GROUP=4 (padded top group).
module tb_and_reduce_pipe;

    localparam logic [26:0] ALL27 = 27'h7FFFFFF;

    logic        clk;
    logic        rst;

    logic [26:0] i_a;
    logic [26:0] m_a;
    logic        z_a;
    logic        v_a;
    logic        q_a;
    logic        ov_a;
    logic        st_a;

    logic [9:0]  i_b;
    logic [9:0]  m_b;
    logic        z_b;
    logic        v_b;
    logic        q_b;
    logic        ov_b;
    logic        st_b;

    int tests_run;
    int tests_failed;

    and_reduce_pipe #(.WIDTH(27), .GROUP(9), .DEB_CNT(4)) u_dut (
        .clk(clk), .rst(rst), .I(i_a), .MASK(m_a), .ZMODE(z_a), .IN_VALID(v_a),
        .Q(q_a), .OUT_VALID(ov_a), .Q_STABLE(st_a)
    );

    and_reduce_pipe #(.WIDTH(10), .GROUP(4), .DEB_CNT(4)) u_dut10 (
        .clk(clk), .rst(rst), .I(i_b), .MASK(m_b), .ZMODE(z_b), .IN_VALID(v_b),
        .Q(q_b), .OUT_VALID(ov_b), .Q_STABLE(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_a = '0; m_a = '0; z_a = 1'b0; v_a = 1'b0;
        i_b = '0; m_b = '0; z_b = 1'b0; v_b = 1'b0;
        step();
        step();
        tests_run++;
        if ({q_a, ov_a, st_a, q_b, ov_b, st_b} !== 6'b000000) begin
            tests_failed++;
            $display("FAIL reset_outputs got %b expected 000000", {q_a, ov_a, st_a, q_b, ov_b, st_b});
        end
        rst = 1'b0;
    endtask

    task automatic test_all_ones();
        logic [1:0] exp_s [4];
        exp_s[0] = 2'b00; exp_s[1] = 2'b11; exp_s[2] = 2'b10; exp_s[3] = 2'b10;
        i_a = ALL27; m_a = ALL27; z_a = 1'b0; v_a = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            v_a = 1'b0;
            tests_run++;
            if ({q_a, ov_a} !== exp_s[c]) begin
                tests_failed++;
                $display("FAIL all_ones_c%0d got q/ov=%b expected %b", c + 1, {q_a, ov_a}, exp_s[c]);
            end
        end
    endtask

    task automatic test_mask();
        logic [26:0] id_s [4];
        logic [26:0] md_s [4];
        logic        zd_s [4];
        logic        ex_s [4];
        id_s[0] = ALL27 & ~(27'd1 << 13); md_s[0] = ALL27;                  zd_s[0] = 1'b0; ex_s[0] = 1'b0;
        id_s[1] = ALL27 & ~(27'd1 << 13); md_s[1] = ALL27 & ~(27'd1 << 13); zd_s[1] = 1'b0; ex_s[1] = 1'b1;
        id_s[2] = 27'd0;                  md_s[2] = 27'd0;                  zd_s[2] = 1'b0; ex_s[2] = 1'b1;
        id_s[3] = ALL27;                  md_s[3] = 27'd0;                  zd_s[3] = 1'b1; ex_s[3] = 1'b1;
        // Beats issued back to back; each result appears two edges after its issue.
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                i_a = id_s[c]; m_a = md_s[c]; z_a = zd_s[c]; v_a = 1'b1;
            end else begin
                v_a = 1'b0;
            end
            step();
            if (c >= 1 && c <= 4) begin
                tests_run++;
                if ({q_a, ov_a} !== {ex_s[c-1], 1'b1}) begin
                    tests_failed++;
                    $display("FAIL mask_beat%0d got q/ov=%b expected %b", c - 1, {q_a, ov_a}, {ex_s[c-1], 1'b1});
                end
            end
        end
    endtask

    task automatic test_padded_group();
        logic [9:0] id_s [4];
        logic       ex_s [4];
        id_s[0] = 10'h3FF; ex_s[0] = 1'b1;
        id_s[1] = 10'h1FF; ex_s[1] = 1'b0;
        id_s[2] = 10'h3F7; ex_s[2] = 1'b0;
        id_s[3] = 10'h3FF; ex_s[3] = 1'b1;
        m_b = 10'h3FF; z_b = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                i_b = id_s[c]; v_b = 1'b1;
            end else begin
                v_b = 1'b0;
            end
            step();
            if (c >= 1 && c <= 4) begin
                tests_run++;
                if ({q_b, ov_b} !== {ex_s[c-1], 1'b1}) begin
                    tests_failed++;
                    $display("FAIL padded_beat%0d got q/ov=%b expected %b", c - 1, {q_b, ov_b}, {ex_s[c-1], 1'b1});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        m_a = ALL27; i_a = 27'd0;
        z_a = 1'b1; v_a = 1'b1;
        step();
        z_a = 1'b0; v_a = 1'b1;
        step();
        v_a = 1'b0; z_a = 1'b1;
        tests_run++;
        if ({q_a, ov_a} !== 2'b11) begin
            tests_failed++;
            $display("FAIL b2b_zmode1 got q/ov=%b expected 11", {q_a, ov_a});
        end
        step();
        tests_run++;
        if ({q_a, ov_a} !== 2'b01) begin
            tests_failed++;
            $display("FAIL b2b_zmode0 got q/ov=%b expected 01", {q_a, ov_a});
        end
        step();
        step();
        tests_run++;
        if ({q_a, ov_a} !== 2'b00) begin
            tests_failed++;
            $display("FAIL idle_hold got q/ov=%b expected 00", {q_a, ov_a});
        end
    endtask

    task automatic test_reset_midstream();
        // Precondition: Q is 0. Issue a true beat, then reset one clock later.
        i_a = ALL27; m_a = ALL27; z_a = 1'b0; v_a = 1'b1;
        step();
        v_a = 1'b0;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({q_a, ov_a, st_a} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rst_async got %b expected 000", {q_a, ov_a, st_a});
        end
        step();
        tests_run++;
        if ({q_a, ov_a, st_a, q_b, ov_b, st_b} !== 6'b000000) begin
            tests_failed++;
            $display("FAIL rst_hold got %b expected 000000", {q_a, ov_a, st_a, q_b, ov_b, st_b});
        end
        // Release reset and issue a new beat right away (all-zeros test of zeros).
        rst = 1'b0;
        i_a = 27'd0; z_a = 1'b1; v_a = 1'b1;
        step();
        v_a = 1'b0;
        tests_run++;
        if ({q_a, ov_a} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rst_discard got q/ov=%b expected 00", {q_a, ov_a});
        end
        step();
        tests_run++;
        if ({q_a, ov_a} !== 2'b11) begin
            tests_failed++;
            $display("FAIL post_rst_beat got q/ov=%b expected 11", {q_a, ov_a});
        end
        step();
    endtask

    task automatic test_debounce();
        logic       vin_s [9];
        logic       tin_s [9];
        logic       st_exp_s [9];
        logic       ov_exp;
        logic       q_exp;
        vin_s[0] = 1'b1; tin_s[0] = 1'b1;
        vin_s[1] = 1'b1; tin_s[1] = 1'b1;
        vin_s[2] = 1'b1; tin_s[2] = 1'b1;
        vin_s[3] = 1'b0; tin_s[3] = 1'b1;
        vin_s[4] = 1'b1; tin_s[4] = 1'b1;
        vin_s[5] = 1'b1; tin_s[5] = 1'b0;
        for (int t = 6; t < 9; t++) begin
            vin_s[t] = 1'b0; tin_s[t] = 1'b0;
        end
        for (int t = 0; t < 9; t++) begin
            st_exp_s[t] = 1'b0;
        end
`ifdef AND_REDUCE_DEBOUNCE_EN
        st_exp_s[6] = 1'b1;
`endif
        // Start from a cleared counter.
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_a = ALL27; z_a = 1'b0;
        q_exp = 1'b0;
        for (int t = 0; t < 9; t++) begin
            v_a = vin_s[t];
            i_a = tin_s[t] ? ALL27 : 27'd0;
            step();
            ov_exp = (t >= 1) ? vin_s[t-1] : 1'b0;
            if (ov_exp) begin
                q_exp = tin_s[t-1];
            end
            tests_run++;
            if ({q_a, ov_a, st_a} !== {q_exp, ov_exp, st_exp_s[t]}) begin
                tests_failed++;
                $display("FAIL debounce_e%0d got q/ov/st=%b expected %b", t, {q_a, ov_a, st_a}, {q_exp, ov_exp, st_exp_s[t]});
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_all_ones();
        test_mask();
        test_padded_group();
        test_back_to_back();
        test_reset_midstream();
        test_debounce();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/and_reduce_pipe.md
AND_REDUCE_PIPE -- requirements
Module: and_reduce_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 27: number of input bits; legal range 2..64.
REQ-002 SHALL have parameter GROUP, default 9: bits reduced per first-stage group; legal range 2..WIDTH.
REQ-003 SHALL have parameter DEB_CNT, default 4: consecutive true results needed for Q_STABLE; legal range 1..255.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port I, input, WIDTH: data bits to reduce.
REQ-007 SHALL have port MASK, input, WIDTH: per-bit enable; 0 excludes the bit.
REQ-008 SHALL have port ZMODE, input, 1: 0 tests all-ones, 1 tests all-zeros.
REQ-009 SHALL have port IN_VALID, input, 1: I/MASK/ZMODE are valid this cycle.
REQ-010 SHALL have port Q, output, 1: registered reduction result.
REQ-011 SHALL have port OUT_VALID, output, 1: Q is valid this cycle.
REQ-012 SHALL have port Q_STABLE, output, 1: debounced result (see Configuration).

Function
REQ-013 SHALL compute an effective bit per position: ZMODE=0 -> I[k] OR NOT MASK[k]; ZMODE=1 -> NOT I[k] OR NOT MASK[k].
REQ-014 SHALL split the effective bits into NG = ceil(WIDTH/GROUP) groups, LSB-first, and pad the missing bits of the top group with 1.
REQ-015 SHALL register each group AND in stage 1, together with a stage-1 valid bit equal to IN_VALID.
REQ-016 SHALL register the AND of all NG group results in stage 2 onto Q, with OUT_VALID equal to the stage-1 valid bit.
REQ-017 SHALL have a fixed latency of 2 clocks from IN_VALID sampled high to OUT_VALID high, with full throughput of one result per clock and no stalls.
REQ-018 SHALL, on a cycle with IN_VALID=0, load stage-1 valid with 0 and shall hold the group registers unchanged.
REQ-019 SHALL, on a stage-2 cycle with stage-1 valid=0, drive OUT_VALID=0 and hold Q at its last value.
REQ-020 SHALL produce Q=1 when MASK is all zero (vacuous truth), in either ZMODE.
REQ-021 SHALL apply ZMODE per beat: it is sampled with I and travels down the pipe with that beat, so mode changes take effect with no bubble.

Reset
REQ-022 SHALL, while rst=1, asynchronously clear the stage-1 group registers to 0, stage-1 valid to 0, Q to 0, OUT_VALID to 0, the debounce counter to 0 and Q_STABLE to 0.
REQ-023 SHALL discard any beat in flight when rst is asserted mid-stream, and shall never emit it.
REQ-024 SHALL accept a new beat on the first rising edge after rst deasserts, with its result appearing 2 clocks later.

Configuration
REQ-025 SHALL compile the debounce logic only when macro AND_REDUCE_DEBOUNCE_EN is defined.
REQ-026 SHALL, with AND_REDUCE_DEBOUNCE_EN defined, implement an 8-bit saturating counter with these rules on each clock:
- OUT_VALID=1 and Q=1: increment, saturating at DEB_CNT.
- OUT_VALID=1 and Q=0: clear to 0.
- OUT_VALID=0: hold.
REQ-027 SHALL, with AND_REDUCE_DEBOUNCE_EN defined, register Q_STABLE = (next counter value == DEB_CNT), so it rises on the same edge that the DEB_CNT-th consecutive valid true result is counted.
REQ-028 SHALL, without AND_REDUCE_DEBOUNCE_EN, tie Q_STABLE to constant 0, include no counter, and leave Q/OUT_VALID behaviour unchanged.

Verification
REQ-029 SHALL cover: defaults, I=27'h7FFFFFF, MASK all ones, ZMODE=0, IN_VALID pulse at cycle 0 -> Q=1 and OUT_VALID=1 at cycle 2 only.
REQ-030 SHALL cover: I=27'h7FFFFFF with bit 13 cleared and MASK[13]=1 -> Q=0; the same beat with MASK[13]=0 -> Q=1.
REQ-031 SHALL cover: WIDTH=10, GROUP=4 (padded top group), I=10'h3FF -> Q=1; I=10'h1FF -> Q=0.
REQ-032 SHALL cover: back-to-back beats ZMODE=1 with I=0, then ZMODE=0 with I=0 -> consecutive outputs Q=1 then Q=0 with no bubble.
REQ-033 SHALL cover: beat issued, then rst pulsed 1 clock later -> OUT_VALID never rises for that beat, and all outputs read 0 during reset.
REQ-034 SHALL cover, with AND_REDUCE_DEBOUNCE_EN and DEB_CNT=4: valid true results 3, gap, 1 -> Q_STABLE rises on the 4th; then one false result -> Q_STABLE falls on the next edge.
